keys_debounce: RTL and testbench

KEYS_DEBOUNCE -- requirements
Module: keys_debounce

---
 rtl/board_pkg.sv | 23 ++
 rtl/key_debounce_cell.sv | 94 +++++++++
 rtl/keys_debounce.sv | 45 ++++
 tb/tb_keys_debounce.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Board-level key configuration shared by the key input path.
// Holds key count, debounce/autorepeat timing and the repeat FSM encoding.
package board_pkg;

    localparam int KEYS_W               = 4;
    localparam int KEY_DEBOUNCE_MS      = 10;
    localparam int KEY_REPEAT_DELAY_MS  = 400;
    localparam int KEY_REPEAT_PERIOD_MS = 100;

    typedef enum logic {
        RPT_WAIT_DELAY = 1'b0,
        RPT_REPEATING  = 1'b1
    } rpt_state_e;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// Single-key synchronizer, debouncer and edge pulse generator.
// Optional autorepeat is enabled by KEYS_AUTOREPEAT_EN.
module key_debounce_cell
    import board_pkg::*;
#(
    parameter int DEB_CYCLES        = 4
`ifdef KEYS_AUTOREPEAT_EN
    ,
    parameter int RPT_DELAY_CYCLES  = 10,
    parameter int RPT_PERIOD_CYCLES = 3
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_i,
    output logic key_o,
    output logic press_o,
    output logic release_o
);

    localparam int CNT_W = max_int($clog2(DEB_CYCLES + 1), 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mismatch;
    logic             flip;
    logic             rise;
    logic             fall;

    assign mismatch = sync_q[1] ^ key_o;
    assign flip     = mismatch && (cnt_q == CNT_LAST);
    assign rise     = flip && !key_o;
    assign fall     = flip && key_o;

    // Counter clears on any agreement, so it can never wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q    <= 2'b00;
            cnt_q     <= '0;
            key_o     <= 1'b0;
            release_o <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], key_i};
            cnt_q     <= (!mismatch || flip) ? '0 : cnt_q + 1'b1;
            key_o     <= flip ? ~key_o : key_o;
            release_o <= fall;
        end
    end

`ifdef KEYS_AUTOREPEAT_EN
    localparam int RPT_MAX = max_int(RPT_DELAY_CYCLES, RPT_PERIOD_CYCLES);
    localparam int RW      = max_int($clog2(RPT_MAX + 1), 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(RPT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(RPT_PERIOD_CYCLES - 1);

    rpt_state_e    rpt_state_q;
    logic [RW-1:0] rpt_cnt_q;
    logic [RW-1:0] rpt_last;

    assign rpt_last = (rpt_state_q == RPT_WAIT_DELAY) ? DELAY_LAST
                                                      : PERIOD_LAST;

    // Repeat timer runs only while the accepted level is held high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rpt_state_q <= RPT_WAIT_DELAY;
            rpt_cnt_q   <= '0;
            press_o     <= 1'b0;
        end else begin
            press_o <= rise;
            if (!key_o || fall) begin
                rpt_state_q <= RPT_WAIT_DELAY;
                rpt_cnt_q   <= '0;
            end else if (rpt_cnt_q == rpt_last) begin
                rpt_state_q <= RPT_REPEATING;
                rpt_cnt_q   <= '0;
                press_o     <= 1'b1;
            end else begin
                rpt_cnt_q <= rpt_cnt_q + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            press_o <= 1'b0;
        end else begin
            press_o <= rise;
        end
    end
`endif

endmodule

// File: rtl/keys_debounce.sv
// Per-key debouncer array between board key inversion and game_top.
// Autorepeat on press_o is enabled by defining KEYS_AUTOREPEAT_EN.
module keys_debounce #(
    parameter int KEYS_W           = board_pkg::KEYS_W,
    parameter int CLK_HZ           = 25_200_000,
    parameter int DEBOUNCE_MS      = board_pkg::KEY_DEBOUNCE_MS,
    parameter int REPEAT_DELAY_MS  = board_pkg::KEY_REPEAT_DELAY_MS,
    parameter int REPEAT_PERIOD_MS = board_pkg::KEY_REPEAT_PERIOD_MS
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [KEYS_W-1:0] keys_i,
    output logic [KEYS_W-1:0] keys_o,
    output logic [KEYS_W-1:0] press_o,
    output logic [KEYS_W-1:0] release_o
);
    import board_pkg::*;

    localparam int DEB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int RPT_DELAY  = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
    localparam int RPT_PERIOD = ms_to_cycles(CLK_HZ, REPEAT_PERIOD_MS);

    if (DEB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_cfg
        $error("keys_debounce: timing parameters must give >= 1 cycle");
    end

    for (genvar i = 0; i < KEYS_W; i++) begin : g_key
        key_debounce_cell #(
            .DEB_CYCLES       (DEB_CYCLES)
`ifdef KEYS_AUTOREPEAT_EN
            ,
            .RPT_DELAY_CYCLES (RPT_DELAY),
            .RPT_PERIOD_CYCLES(RPT_PERIOD)
`endif
        ) u_cell (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .key_i    (keys_i[i]),
            .key_o    (keys_o[i]),
            .press_o  (press_o[i]),
            .release_o(release_o[i])
        );
    end

endmodule

// File: tb/tb_keys_debounce.sv
// Directed bench for keys_debounce at CLK_HZ=1000, 4 ms debounce,
// 10/3 ms autorepeat (active only when KEYS_AUTOREPEAT_EN is defined).
module tb_keys_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] keys = 2'b00;
    logic [1:0] keys_q;
    logic [1:0] press;
    logic [1:0] rel;

    int n_checks = 0;
    int n_errors = 0;
    int n_overlap = 0;

    always #5 clk = ~clk;

    keys_debounce #(
        .KEYS_W          (2),
        .CLK_HZ          (1000),
        .DEBOUNCE_MS     (4),
        .REPEAT_DELAY_MS (10),
        .REPEAT_PERIOD_MS(3)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .keys_i   (keys),
        .keys_o   (keys_q),
        .press_o  (press),
        .release_o(rel)
    );

    always @(negedge clk) begin
        if (|(press & rel)) n_overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] got,
                       input logic [1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] ek,
                           input logic [1:0] ep, input logic [1:0] er);
        chk({tag, ".keys"}, keys_q, ek);
        chk({tag, ".press"}, press, ep);
        chk({tag, ".release"}, rel, er);
    endtask

    // Press pulse expected k cycles after acceptance while held.
    function automatic bit rpt_pulse(input int k);
`ifdef KEYS_AUTOREPEAT_EN
        return (k == 0) || (k >= 10 && (k - 10) % 3 == 0);
`else
        return (k == 0);
`endif
    endfunction

    // key0 high for edges 1..hold: accept at edge 6, drop at hold+6.
    task automatic run_hold(input string tag, input int hold);
        for (int n = 1; n <= hold + 8; n++) begin
            logic ek, ep, er;
            keys = {1'b0, (n <= hold)};
            tick();
            ek = (n >= 6) && (n < hold + 6);
            ep = ek && rpt_pulse(n - 6);
            er = (n == hold + 6);
            chk_all($sformatf("%s.e%0d", tag, n), {1'b0, ek},
                    {1'b0, ep}, {1'b0, er});
        end
    endtask

    initial begin
        rst  = 1'b1;
        keys = 2'b00;
        tick();
        tick();
        chk_all("reset", 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        tick();

        // Single press: 6 edges from first sample, key1 untouched.
        keys = 2'b01;
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk_all($sformatf("press.e%0d", n), 2'b00, 2'b00, 2'b00);
        end
        tick();
        chk_all("press.e6", 2'b01, 2'b01, 2'b00);
        tick();
        chk_all("press.e7", 2'b01, 2'b00, 2'b00);
        keys = 2'b00;
        for (int n = 1; n <= 5; n++) tick();
        chk_all("unpress.e5", 2'b01, 2'b00, 2'b00);
        tick();
        chk_all("unpress.e6", 2'b00, 2'b00, 2'b01);
        tick();
        chk_all("unpress.e7", 2'b00, 2'b00, 2'b00);

        // Bounce shorter than the debounce window is ignored.
        for (int r = 0; r < 5; r++) begin
            keys = 2'b01;
            for (int c = 0; c < 3; c++) begin
                tick();
                chk_all($sformatf("bounce.r%0d.h%0d", r, c),
                        2'b00, 2'b00, 2'b00);
            end
            keys = 2'b00;
            for (int c = 0; c < 2; c++) begin
                tick();
                chk_all($sformatf("bounce.r%0d.l%0d", r, c),
                        2'b00, 2'b00, 2'b00);
            end
        end
        for (int n = 0; n < 6; n++) tick();
        chk_all("bounce.settle", 2'b00, 2'b00, 2'b00);

        // Press held 20 cycles, then 30 cycles.
        run_hold("hold20", 20);
        run_hold("hold30", 30);

        // Both keys together behave identically.
        keys = 2'b11;
        for (int n = 1; n <= 5; n++) tick();
        chk_all("both.e5", 2'b00, 2'b00, 2'b00);
        tick();
        chk_all("both.e6", 2'b11, 2'b11, 2'b00);
        keys = 2'b00;
        for (int n = 1; n <= 5; n++) tick();
        chk_all("both_rel.e5", 2'b11, 2'b00, 2'b00);
        tick();
        chk_all("both_rel.e6", 2'b00, 2'b00, 2'b11);

        // Reset 2 cycles into a held press discards it.
        keys = 2'b01;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk_all("midrst.a", 2'b00, 2'b00, 2'b00);
        tick();
        chk_all("midrst.b", 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            tick();
            chk_all($sformatf("postrst.e%0d", n), 2'b00, 2'b00, 2'b00);
        end
        tick();
        chk_all("postrst.e6", 2'b01, 2'b01, 2'b00);

        // Reset with key accepted: cleared, no release pulse.
        rst = 1'b1;
        tick();
        chk_all("heldrst", 2'b00, 2'b00, 2'b00);
        keys = 2'b00;
        rst  = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            chk_all($sformatf("heldrst.q%0d", n), 2'b00, 2'b00, 2'b00);
        end

        n_checks++;
        assert (n_overlap == 0) else begin
            n_errors++;
            $error("FAIL overlap: observed=%0d expected=0", n_overlap);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
